alu_sched: RTL
==============

Name: alu_sched

Overview:
Round-robin scheduler that shares one registered 16-bit ALU (4-bit ALU_FUN, four one-hot class flags) among NREQ requesters. It arbitrates requests, drives the ALU operand/function inputs, waits out the ALU pipeline latency and returns the result and flags on one shared, tagged response channel. It sits between the ALU and its client blocks, and is the only driver of the ALU inputs.

Parameters:
NREQ, 4, number of requesters (2..2**ID_W)
ID_W, 2, requester tag width
DW, 16, operand/result width (must match ALU)
ALU_LAT, 1, ALU clock cycles from input sampled to ALU_OUT updated

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester grant/accept, one-hot or zero
req_a  in  NREQ*DW  flattened operand A, requester i at [i*DW+:DW]
req_b  in  NREQ*DW  flattened operand B
req_fun  in  NREQ*4  flattened ALU function code
resp_valid  out  1  response valid
resp_ready  in  1  response consumer ready
resp_id  out  ID_W  index of requester that owns the response
resp_data  out  DW  captured ALU_OUT
resp_flags  out  4  captured {ARITH,LOGIC,CMP,SHIFT}
resp_err  out  1  guarded-operation error (see Optional Feature), else 0
alu_a  out  DW  ALU operand A (registered)
alu_b  out  DW  ALU operand B (registered)
alu_fun  out  4  ALU function (registered)
alu_out  in  DW  ALU result
alu_flags  in  4  ALU flags {ARITH,LOGIC,CMP,SHIFT}
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, asynchronous on rst_n low: state=IDLE, rr pointer=NREQ-1, req_ready=0, resp_valid=0, resp_id=0, resp_data=0, resp_flags=0, resp_err=0, alu_a=0, alu_b=0, alu_fun=4'b1111 (NOP), busy=0.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational: a one-hot grant to the first valid requester after the rr pointer, wrapping from NREQ-1 to 0. It is all-zero if no req_valid is high.
  - Accept happens on the edge where req_valid[g]&req_ready[g] is high. On that edge: alu_a/alu_b/alu_fun load requester g's fields, tag register=g, rr pointer=g, cnt=0, next state EXEC.
- EXEC:
  - req_ready=0. Operands and function are held stable.
  - cnt increments each cycle. On the edge where cnt==ALU_LAT: resp_data<=alu_out, resp_flags<=alu_flags, resp_id<=tag, resp_valid<=1, alu_fun<=NOP, next state RESP.
  - The response is visible ALU_LAT+1 cycles after the accept edge (2 cycles at default).
- RESP:
  - Outputs are held stable while resp_valid&&!resp_ready.
  - On the resp_valid&resp_ready edge: resp_valid<=0, next state IDLE.
  - No new accept occurs in that same cycle; minimum issue interval is ALU_LAT+3 cycles.
- Input function codes are passed through unmodified; 4'b1111 is a legal request (result 0, flags 0000).
- Inputs changing while not accepted have no effect. Only the accepted requester's fields are captured.
- A requester dropping req_valid before accept loses its turn without penalty.
- Reset mid-operation: an in-flight operation is discarded with no response issued, and the ALU is returned to NOP.

Optional Feature:
ALU_SCHED_DIV0_GUARD_EN:
- Defined: an accepted request with fun==4'b0011 and b==0 is not issued to the ALU. alu_* stay at NOP, the scheduler goes directly to RESP on the next edge, and returns resp_data=16'hFFFF, resp_flags=4'b1000, resp_err=1.
- Not defined: such a request is issued normally, and resp_err is tied to 0.

Decomposition:
- Package alu_sched_pkg holds:
  - ALU function code constants (ADD=0 .. SHL=14, NOP=15, DIV=3)
  - flag bit indices (ARITH=3, LOGIC=2, CMP=1, SHIFT=0)
  - FSM state encoding
- Sub-module rr_arbiter(NREQ): inputs req vector and pointer; output one-hot grant. Purely combinational.

Test Plan:
1. Single add, default timing: req0 a=16'h00A2, b=16'h0055, fun=0, resp_ready=1. Expect resp_valid 2 cycles after accept, resp_data=247, resp_flags=1000, resp_id=0.
2. Round-robin: all four req_valid held high with distinct ops (sub, mul, and, shr; a=0x00A2, b=0x0055). Expect grants in order 0,1,2,3,0 and results 77, 13770, 0, 81 tagged with ids 0..3.
3. Backpressure: resp_ready=0 for 5 cycles after resp_valid. Expect resp_* stable, req_ready=0, busy=1; after resp_ready=1, one handshake, then IDLE.
4. Compare op then NOP: fun=4'b1011 gives resp_data=2, flags=0010; fun=4'b1111 gives resp_data=0, flags=0000; alu_fun reads 1111 whenever idle.
5. Reset mid-EXEC: assert rst_n=0 asynchronously between clock edges. Expect all outputs at reset values immediately and no response after release.
6. With ALU_SCHED_DIV0_GUARD_EN: fun=3, b=0 gives resp_data=16'hFFFF, resp_err=1, alu_fun never leaves 1111. Without the macro, the same request is issued to the ALU and resp_err=0.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU scheduler: ALU function codes, flag bit
// positions and the scheduler FSM state encoding.
package alu_sched_pkg;

   // ALU function codes (4-bit ALU_FUN)
   localparam logic [3:0] FUN_ADD   = 4'd0;
   localparam logic [3:0] FUN_SUB   = 4'd1;
   localparam logic [3:0] FUN_MUL   = 4'd2;
   localparam logic [3:0] FUN_DIV   = 4'd3;
   localparam logic [3:0] FUN_AND   = 4'd4;
   localparam logic [3:0] FUN_OR    = 4'd5;
   localparam logic [3:0] FUN_NAND  = 4'd6;
   localparam logic [3:0] FUN_NOR   = 4'd7;
   localparam logic [3:0] FUN_XOR   = 4'd8;
   localparam logic [3:0] FUN_XNOR  = 4'd9;
   localparam logic [3:0] FUN_CMPEQ = 4'd10;
   localparam logic [3:0] FUN_CMPGT = 4'd11;
   localparam logic [3:0] FUN_CMPLT = 4'd12;
   localparam logic [3:0] FUN_SHR   = 4'd13;
   localparam logic [3:0] FUN_SHL   = 4'd14;
   localparam logic [3:0] FUN_NOP   = 4'd15;

   // Bit positions inside the one-hot {ARITH,LOGIC,CMP,SHIFT} flag vector
   localparam int FLAG_ARITH = 3;
   localparam int FLAG_LOGIC = 2;
   localparam int FLAG_CMP   = 1;
   localparam int FLAG_SHIFT = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // One-hot flag vector with only the given class bit set
   function automatic logic [3:0] flag_mask(input int idx);
      return 4'(1 << idx);
   endfunction

endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request
// strictly after the pointer position, wrapping from NREQ-1 back to 0.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic [NREQ-1:0] grant
);

   logic            found;
   logic [ID_W-1:0] idx;

   // Scan from ptr+1 around the ring and keep only the first hit
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = ID_W'((int'(ptr) + i) % NREQ);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one registered ALU among NREQ requesters.
// Accepts one request at a time, drives the ALU inputs, waits ALU_LAT
// cycles, then returns result/flags on a tagged response channel.
// Optional build macro: ALU_SCHED_DIV0_GUARD_EN -- when defined, a DIV
// request with b==0 bypasses the ALU and returns 16'hFFFF with resp_err=1.
module alu_sched #(
   parameter int NREQ    = 4,
   parameter int ID_W    = 2,
   parameter int DW      = 16,
   parameter int ALU_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*DW-1:0] req_a,
   input  logic [NREQ*DW-1:0] req_b,
   input  logic [NREQ*4-1:0] req_fun,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [ID_W-1:0]   resp_id,
   output logic [DW-1:0]     resp_data,
   output logic [3:0]        resp_flags,
   output logic              resp_err,
   output logic [DW-1:0]     alu_a,
   output logic [DW-1:0]     alu_b,
   output logic [3:0]        alu_fun,
   input  logic [DW-1:0]     alu_out,
   input  logic [3:0]        alu_flags,
   output logic              busy
);

   import alu_sched_pkg::*;

   localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

   state_t          state;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] tag;
   logic [CNT_W-1:0] cnt;
   logic [NREQ-1:0] grant;
   logic [ID_W-1:0] g_idx;
   logic [DW-1:0]   sel_a;
   logic [DW-1:0]   sel_b;
   logic [3:0]      sel_fun;
   logic            accept;
   logic            div0_skip;

   rr_arbiter #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_arb (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (grant)
   );

   // Grants are only offered in IDLE and are forced low while reset is held
   assign req_ready = (state == ST_IDLE && rst_n) ? grant : '0;
   assign accept    = |(req_valid & req_ready);
   assign busy      = (state != ST_IDLE);

   // Encode the one-hot grant and select that requester's fields
   always_comb begin
      g_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) g_idx = ID_W'(i);
      end
      sel_a   = req_a[int'(g_idx)*DW +: DW];
      sel_b   = req_b[int'(g_idx)*DW +: DW];
      sel_fun = req_fun[int'(g_idx)*4 +: 4];
   end

`ifdef ALU_SCHED_DIV0_GUARD_EN
   logic err_q;
   assign div0_skip = (sel_fun == FUN_DIV) && (sel_b == '0);
   assign resp_err  = err_q;
`else
   assign div0_skip = 1'b0;
   assign resp_err  = 1'b0;
`endif

   // Scheduler FSM: accept, hold operands for the ALU latency, present response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         rr_ptr     <= ID_W'(NREQ - 1);
         tag        <= '0;
         cnt        <= '0;
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_data  <= '0;
         resp_flags <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_fun    <= FUN_NOP;
`ifdef ALU_SCHED_DIV0_GUARD_EN
         err_q      <= 1'b0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  rr_ptr <= g_idx;
                  tag    <= g_idx;
                  cnt    <= '0;
                  if (div0_skip) begin
                     // ALU stays at NOP; answer directly with the saturated quotient
                     resp_data  <= '1;
                     resp_flags <= flag_mask(FLAG_ARITH);
                     resp_id    <= g_idx;
                     resp_valid <= 1'b1;
`ifdef ALU_SCHED_DIV0_GUARD_EN
                     err_q      <= 1'b1;
`endif
                     state      <= ST_RESP;
                  end else begin
                     alu_a   <= sel_a;
                     alu_b   <= sel_b;
                     alu_fun <= sel_fun;
                     state   <= ST_EXEC;
                  end
               end
            end
            ST_EXEC: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(ALU_LAT)) begin
                  resp_data  <= alu_out;
                  resp_flags <= alu_flags;
                  resp_id    <= tag;
                  resp_valid <= 1'b1;
                  alu_fun    <= FUN_NOP;
`ifdef ALU_SCHED_DIV0_GUARD_EN
                  err_q      <= 1'b0;
`endif
                  state      <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
